// File: rtl/soc_ram_pkg.sv
// Shared types and helpers for the SoC RAM slave: FSM state, lane count, byte parity.
package soc_ram_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    function automatic int bytes_of(input int databit);
        return databit / 8;
    endfunction

    // Even parity: the stored bit makes the 9-bit lane have an even number of ones.
    function automatic logic even_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/soc_ram_ctrl_if.sv
// Request/response valid-ready bundle between the bus-to-SRAM bridge and the RAM slave.
interface soc_ram_ctrl_if #(
    parameter int ADDRBIT = 16,
    parameter int DATABIT = 32
) ();
    import soc_ram_pkg::*;

    localparam int BYTES = bytes_of(DATABIT);

    logic               req_valid;
    logic               req_ready;
    logic               req_wen;
    logic [ADDRBIT-1:0] req_addr;
    logic [DATABIT-1:0] req_wdata;
    logic [BYTES-1:0]   req_byte_en;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DATABIT-1:0] rsp_rdata;
    logic               rsp_err;
    logic               rsp_perr;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_byte_en, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_perr
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_byte_en, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_perr
    );

endinterface

// File: rtl/soc_ram_array.sv
// Single-port storage with byte-lane write enables and a registered read port.
// With SOC_RAM_PARITY_EN defined, bit DATABIT+i holds the parity of byte lane i.
module soc_ram_array
    import soc_ram_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int DATABIT = 32,
    parameter int WIDTH   = 32,
    parameter int IDXW    = 4
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [IDXW-1:0]      addr,
    input  logic [DATABIT/8-1:0] wmask,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata
);

    localparam int unsigned BYTES = bytes_of(DATABIT);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < BYTES; i++) begin
                    if (wmask[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
`ifdef SOC_RAM_PARITY_EN
                        mem[addr][DATABIT+i] <= wdata[DATABIT+i];
`endif
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/soc_ram_ctrl.sv
// SoC RAM slave: post-reset clear FSM, window decode, single-entry response register.
// Optional per-byte parity storage and checking enabled by defining SOC_RAM_PARITY_EN.
module soc_ram_ctrl
    import soc_ram_pkg::*;
#(
    parameter int ADDRBIT    = 16,
    parameter int DATABIT    = 32,
    parameter int DEPTH      = 65536,
    parameter int BASEADDR   = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic          clk,
    input  logic          rst,
    soc_ram_ctrl_if.slave bus,
    output logic          init_done
);

    localparam int unsigned BYTES = bytes_of(DATABIT);
    localparam int unsigned IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef SOC_RAM_PARITY_EN
    localparam int unsigned ARRW  = DATABIT + BYTES;
`else
    localparam int unsigned ARRW  = DATABIT;
`endif
    localparam logic [ADDRBIT:0] BASE_W   = (ADDRBIT+1)'(BASEADDR);
    localparam logic [ADDRBIT:0] DEPTH_W  = (ADDRBIT+1)'(DEPTH);
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(DEPTH - 1);

    state_t            state;
    logic [IDXW-1:0]   init_idx;
    logic              rsp_rd;
    logic              accept;
    logic              in_range;
    logic [ADDRBIT:0]  addr_ext;
    logic [ADDRBIT:0]  offset;
    logic              arr_en;
    logic              arr_we;
    logic [IDXW-1:0]   arr_addr;
    logic [BYTES-1:0]  arr_mask;
    logic [ARRW-1:0]   arr_wdata;
    logic [ARRW-1:0]   arr_rdata;

    assign bus.req_ready = init_done && (!bus.rsp_valid || bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    // One extra bit keeps the subtraction from wrapping below BASEADDR.
    assign addr_ext = {1'b0, bus.req_addr};
    assign offset   = addr_ext - BASE_W;
    assign in_range = (addr_ext >= BASE_W) && (offset < DEPTH_W);

    always_comb begin
        arr_en    = 1'b0;
        arr_we    = 1'b0;
        arr_addr  = offset[IDXW-1:0];
        arr_mask  = '0;
        arr_wdata = '0;
        if (state == ST_INIT) begin
            arr_en   = 1'b1;
            arr_we   = 1'b1;
            arr_addr = init_idx;
            arr_mask = '1;
        end else if (accept && in_range) begin
            arr_en   = 1'b1;
            arr_we   = bus.req_wen;
            arr_mask = bus.req_byte_en;
            for (int unsigned i = 0; i < BYTES; i++) begin
                arr_wdata[i*8 +: 8] = bus.req_wdata[i*8 +: 8];
`ifdef SOC_RAM_PARITY_EN
                arr_wdata[DATABIT+i] = even_par(bus.req_wdata[i*8 +: 8]);
`endif
            end
        end
    end

    soc_ram_array #(
        .DEPTH   (DEPTH),
        .DATABIT (DATABIT),
        .WIDTH   (ARRW),
        .IDXW    (IDXW)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (arr_we),
        .addr  (arr_addr),
        .wmask (arr_mask),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
            init_idx      <= '0;
            init_done     <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            rsp_rd        <= 1'b0;
        end else if (state == ST_INIT) begin
            init_idx <= init_idx + 1'b1;
            if (init_idx == LAST_IDX) begin
                state     <= ST_RUN;
                init_done <= 1'b1;
            end
        end else begin
            init_done <= 1'b1;
            if (accept) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_err   <= !in_range;
                rsp_rd        <= !bus.req_wen && in_range;
            end else if (bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
                bus.rsp_err   <= 1'b0;
                rsp_rd        <= 1'b0;
            end
        end
    end

    // The array read register only reloads on an accepted read, so it holds during back-pressure.
    assign bus.rsp_rdata = rsp_rd ? arr_rdata[DATABIT-1:0] : '0;

`ifdef SOC_RAM_PARITY_EN
    logic [BYTES-1:0] lane_bad;

    always_comb begin
        lane_bad = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            lane_bad[i] = even_par(arr_rdata[i*8 +: 8]) != arr_rdata[DATABIT+i];
        end
    end

    assign bus.rsp_perr = rsp_rd && (|lane_bad);
`else
    assign bus.rsp_perr = 1'b0;
`endif

endmodule

// File: tb/tb_soc_ram_ctrl.sv
// Directed bench for soc_ram_ctrl: scoreboard of expected responses filled on accept.
module tb_soc_ram_ctrl;

    localparam int ADDRBIT = 16;
    localparam int DATABIT = 32;
    localparam int DEPTH   = 16;
    localparam int BASE    = 'h100;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        perr;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    logic [31:0] flip  [DEPTH];
    string       cur_tag;
    logic        accepted;

    always #5 clk = ~clk;

    soc_ram_ctrl_if #(.ADDRBIT(ADDRBIT), .DATABIT(DATABIT)) bus ();

    soc_ram_ctrl #(
        .ADDRBIT    (ADDRBIT),
        .DATABIT    (DATABIT),
        .DEPTH      (DEPTH),
        .BASEADDR   (BASE),
        .INIT_CLEAR (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .init_done (init_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    task automatic model_accept();
        exp_t        e;
        int          a;
        logic [3:0]  i4;
        a       = int'(bus.req_addr);
        i4      = 4'(a - BASE);
        e.tag   = cur_tag;
        e.rdata = '0;
        e.err   = 1'b0;
        e.perr  = 1'b0;
        if (a < BASE || a >= BASE + DEPTH) begin
            e.err = 1'b1;
        end else if (bus.req_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.req_byte_en[b]) begin
                    model[i4][b*8 +: 8] = bus.req_wdata[b*8 +: 8];
                    flip[i4][b*8 +: 8]  = 8'h00;
                end
            end
        end else begin
            e.rdata = model[i4] ^ flip[i4];
            e.perr  = |flip[i4];
        end
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_rdata"}, bus.rsp_rdata, e.rdata);
                chk({e.tag, "_err"}, 32'(bus.rsp_err), 32'(e.err));
                chk({e.tag, "_perr"}, 32'(bus.rsp_perr), 32'(e.perr));
            end
        end
        accepted = bus.req_valid && bus.req_ready;
        if (accepted) model_accept();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_fields();
        bus.req_wen     = 1'($urandom);
        bus.req_addr    = 16'($urandom);
        bus.req_wdata   = $urandom;
        bus.req_byte_en = 4'($urandom);
    endtask

    task automatic issue(input string tag, input logic wen, input logic [15:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, output int waited);
        cur_tag         = tag;
        bus.req_valid   = 1'b1;
        bus.req_wen     = wen;
        bus.req_addr    = addr;
        bus.req_wdata   = wdata;
        bus.req_byte_en = be;
        waited          = 0;
        accepted        = 1'b0;
        while (!accepted && waited < 50) begin
            step();
            waited++;
        end
        bus.req_valid = 1'b0;
        idle_fields();
        chk({tag, "_accepted"}, 32'(accepted), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() > 0 && n < 50) begin
            step();
            n++;
        end
        chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        int n;
        rst = 1'b1;
        step();
        step();
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        chk({tag, "_rsp_perr"}, 32'(bus.rsp_perr), 32'd0);
        chk({tag, "_init_done"}, 32'(init_done), 32'd0);
        sb.delete();
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = '0;
            flip[i]  = '0;
        end
        bus.rsp_ready = 1'b1;
        rst = 1'b0;
        n = 0;
        while (!init_done && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_init_cycles"}, 32'(n), 32'd16);
        chk({tag, "_ready_after_init"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        int w;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        idle_fields();

        do_reset("por");

        for (int a = 0; a < DEPTH; a++) begin
            issue("clear_rd", 1'b0, 16'(BASE + a), '0, '0, w);
        end
        drain("clear");

        issue("be0101_wr", 1'b1, 16'(BASE + 3), 32'hDEADBEEF, 4'b0101, w);
        issue("be0101_rd", 1'b0, 16'(BASE + 3), '0, '0, w);
        drain("be0101");

        issue("be0_wr", 1'b1, 16'(BASE + 5), 32'hFFFFFFFF, 4'b0000, w);
        issue("be0_rd", 1'b0, 16'(BASE + 5), '0, '0, w);
        drain("be0");

        issue("below_rd", 1'b0, 16'h00FF, '0, '0, w);
        issue("above_rd", 1'b0, 16'h0110, '0, '0, w);
        issue("top_rd",   1'b0, 16'h010F, '0, '0, w);
        issue("above_wr", 1'b1, 16'h0110, 32'h11111111, 4'hF, w);
        issue("noalias_rd", 1'b0, 16'(BASE), '0, '0, w);
        drain("window");

        bus.rsp_ready = 1'b0;
        issue("stall_rd", 1'b0, 16'(BASE + 3), '0, '0, w);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
            chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall_rdata", bus.rsp_rdata, 32'h00AD00EF);
        end
        bus.rsp_ready = 1'b1;
        step();
        chk("stall_one_beat", 32'(bus.rsp_valid), 32'd0);
        chk("stall_sb_empty", 32'(sb.size()), 32'd0);

        issue("b2b_wr", 1'b1, 16'(BASE + 7), 32'hA5A5A5A5, 4'hF, w);
        chk("b2b_wr_wait", 32'(w), 32'd1);
        issue("b2b_rd", 1'b0, 16'(BASE + 7), '0, '0, w);
        chk("b2b_rd_wait", 32'(w), 32'd1);
        step();
        chk("b2b_rd_sb_empty", 32'(sb.size()), 32'd0);
        drain("b2b");

`ifdef SOC_RAM_PARITY_EN
        issue("par_wr", 1'b1, 16'(BASE + 2), 32'h12345678, 4'hF, w);
        drain("par_wr");
        dut.u_array.mem[2][9] = ~dut.u_array.mem[2][9];
        flip[2] = 32'h0000_0200;
        issue("par_rd", 1'b0, 16'(BASE + 2), '0, '0, w);
        drain("par");
`endif

        bus.rsp_ready = 1'b0;
        issue("run_rst_rd", 1'b0, 16'(BASE + 7), '0, '0, w);
        do_reset("run_rst");
        issue("recleared_rd", 1'b0, 16'(BASE + 3), '0, '0, w);
        issue("recleared_rd7", 1'b0, 16'(BASE + 7), '0, '0, w);
        drain("recleared");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
